sa_psum_collector: RTL

- Sits directly downstream of the systolic array and consumes its bottom-row psum outputs.
- The array emits column l's psum l cycles after column 0, so outputs arrive skewed. This block deskews the lanes into aligned rows.
- Aligned rows are accumulated across a programmable number of K-tile passes in an internal row buffer.
- Final sums are pushed into an output FIFO with a valid/ready handshake toward the writeback stage.

---
 rtl/sa_psum_collector.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sa_psum_collector.sv
// Deskews the systolic array's bottom-row psums into aligned rows, accumulates them over K passes
// and queues the final rows in an output FIFO. Define SA_PSUM_COLLECT_RELU_EN to clamp negative final lanes to 0.
module sa_psum_collector #(
  parameter int PE_SIZE    = 4,
  parameter int PSUM_WIDTH = 32,
  parameter int PASS_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
  input  logic [PE_SIZE-1:0]            psum_en_i,
  input  logic                          start_i,
  input  logic [PASS_WIDTH-1:0]         pass_cnt_i,
  output logic [PSUM_WIDTH*PE_SIZE-1:0] out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          align_err_o
);

  localparam int ROW_W  = PSUM_WIDTH * PE_SIZE;
  localparam int RIDX_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                                   state_q, state_d;
  logic                                     busy_q, busy_d;
  logic [PE_SIZE-1:0][PSUM_WIDTH-1:0]       al_data_s;
  logic [PE_SIZE-1:0]                       al_en_s;
  logic                                     row_ok_s, row_partial_s;
  logic                                     accept_s, load_s, buf_we_s, push_req_s;
  logic                                     final_s, last_row_s;
  logic [PASS_WIDTH-1:0]                    pass_total_q, pass_idx_q;
  logic [RIDX_W-1:0]                        row_idx_q;
  logic [PE_SIZE-1:0][PE_SIZE-1:0][PSUM_WIDTH-1:0] buf_q;
  logic [PE_SIZE-1:0][PSUM_WIDTH-1:0]       sum_s;
  logic [ROW_W-1:0]                         push_row_s;
  logic [FIFO_DEPTH-1:0][ROW_W-1:0]         fifo_mem_q;
  logic [PTR_W-1:0]                         wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                         fifo_cnt_q, fifo_cnt_d;
  logic                                     fifo_full_s, push_s, pop_s, drop_s;
  logic [ROW_W-1:0]                         head_q, head_d;
  logic                                     valid_q;
  logic                                     overflow_q, align_err_q;

  function automatic logic [PSUM_WIDTH-1:0] final_lane(input logic [PSUM_WIDTH-1:0] v);
`ifdef SA_PSUM_COLLECT_RELU_EN
    final_lane = v[PSUM_WIDTH-1] ? '0 : v;
`else
    final_lane = v;
`endif
  endfunction

  // Lane l is delayed PE_SIZE-1-l cycles so that every lane of a row lines up with the last lane.
  for (genvar l = 0; l < PE_SIZE; l++) begin : g_lane
    localparam int STG = PE_SIZE - 1 - l;
    logic [PSUM_WIDTH-1:0] lane_in_s;
    assign lane_in_s = psum_row_i[PSUM_WIDTH*(PE_SIZE-1-l) +: PSUM_WIDTH];
    if (STG == 0) begin : g_pass
      assign al_data_s[l] = lane_in_s;
      assign al_en_s[l]   = psum_en_i[l];
    end else begin : g_pipe
      logic [STG-1:0][PSUM_WIDTH-1:0] data_q;
      logic [STG-1:0]                 en_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          en_q   <= '0;
        end else begin
          data_q[0] <= lane_in_s;
          en_q[0]   <= psum_en_i[l];
          for (int s = 1; s < STG; s++) begin
            data_q[s] <= data_q[s-1];
            en_q[s]   <= en_q[s-1];
          end
        end
      end
      assign al_data_s[l] = data_q[STG-1];
      assign al_en_s[l]   = en_q[STG-1];
    end
  end

  assign row_ok_s      = &al_en_s;
  assign row_partial_s = (|al_en_s) && !row_ok_s;
  assign final_s       = (pass_idx_q == (pass_total_q - PASS_WIDTH'(1)));
  assign last_row_s    = (row_idx_q == RIDX_W'(PE_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_ACCUM; else state_d = ST_IDLE;
      ST_ACCUM: if (push_req_s && last_row_s) state_d = ST_DRAIN; else state_d = ST_ACCUM;
      ST_DRAIN: if (fifo_cnt_q == '0) state_d = ST_IDLE; else state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_s = 1'b0;
    load_s   = 1'b0;
    case (state_q)
      ST_IDLE:  load_s   = start_i;
      ST_ACCUM: accept_s = row_ok_s;
      ST_DRAIN: accept_s = 1'b0;
      default:  accept_s = 1'b0;
    endcase
    buf_we_s   = accept_s && !final_s;
    push_req_s = accept_s && final_s;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_total_q <= '0;
      pass_idx_q   <= '0;
      row_idx_q    <= '0;
    end else if (load_s) begin
      pass_total_q <= (pass_cnt_i == '0) ? PASS_WIDTH'(1) : pass_cnt_i;
      pass_idx_q   <= '0;
      row_idx_q    <= '0;
    end else if (accept_s) begin
      if (last_row_s) begin
        row_idx_q  <= '0;
        pass_idx_q <= pass_idx_q + PASS_WIDTH'(1);
      end else begin
        row_idx_q  <= row_idx_q + RIDX_W'(1);
      end
    end
  end

  // First pass overwrites the buffer entry; later passes wrap-add onto it.
  always_comb begin
    sum_s      = '0;
    push_row_s = '0;
    for (int l = 0; l < PE_SIZE; l++) begin
      if (pass_idx_q == '0) begin
        sum_s[l] = al_data_s[l];
      end else begin
        sum_s[l] = buf_q[row_idx_q][l] + al_data_s[l];
      end
      push_row_s[PSUM_WIDTH*(PE_SIZE-1-l) +: PSUM_WIDTH] = final_lane(sum_s[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (buf_we_s) begin
      buf_q[row_idx_q] <= sum_s;
    end
  end

  assign fifo_full_s = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_s       = valid_q && out_ready_i;
  assign push_s      = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s      = push_req_s && fifo_full_s && !pop_s;
  assign fifo_cnt_d  = fifo_cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
  assign rd_ptr_d    = rd_ptr_q + PTR_W'(pop_s);

  // The head register follows the next oldest entry, bypassing a push that lands in that slot.
  always_comb begin
    head_d = head_q;
    if (fifo_cnt_d != '0) begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_row_s;
      end else begin
        head_d = fifo_mem_q[rd_ptr_d];
      end
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= push_row_s;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      head_q      <= head_d;
      valid_q     <= (fifo_cnt_d != '0);
      overflow_q  <= overflow_q | drop_s;
      align_err_q <= align_err_q | row_partial_s;
    end
  end

  assign out_data_o  = head_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;
  assign align_err_o = align_err_q;

endmodule
